load_queue: RTL and testbench

- Parametrised circular load queue built from multiple load-buffer entries (valid, address, address_valid, executed, succeeded, store_mask, rob_tag).
- Sits between dispatch/AGU and the data-cache/forwarding path of the out-of-order core.
- Allocates in program order and accepts addresses out of order.
- Issues the oldest address-ready load, tracks completion, retires in order on ROB commit, and squashes on flush.

---
 rtl/load_queue.sv | 194 +++++++++++++++++++
 tb/tb_load_queue.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_queue.sv
`default_nettype none
// ============================================================================
// Module      : load_queue
// Description : Circular load queue. Loads are allocated in program order,
//               receive addresses out of order, the oldest address-ready
//               load is offered for issue, and loads retire in order on ROB
//               commit. A flush squashes every entry.
// Revision    : 1.0 - initial release
// ============================================================================
module load_queue #(
    parameter int XLEN          = 32,
    parameter int LDQ_SIZE      = 8,
    parameter int STQ_BUF_SIZE  = 8,
    parameter int ROB_TAG_WIDTH = 5,
    parameter int IDXW          = $clog2(LDQ_SIZE)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    // dispatch
    input  logic                            alloc_valid,
    input  logic [ROB_TAG_WIDTH-1:0]        alloc_rob_tag,
    input  logic [STQ_BUF_SIZE-1:0]         alloc_store_mask,
    output logic                            alloc_ready,
    output logic [IDXW-1:0]                 alloc_index,
    // AGU
    input  logic                            addr_valid,
    input  logic [IDXW-1:0]                 addr_index,
    input  logic [XLEN-1:0]                 addr,
    // issue to cache / forwarding
    output logic                            issue_valid,
    input  logic                            issue_ready,
    output logic [IDXW-1:0]                 issue_index,
    output logic [XLEN-1:0]                 issue_address,
    output logic [STQ_BUF_SIZE-1:0]         issue_store_mask,
    output logic [ROB_TAG_WIDTH-1:0]        issue_rob_tag,
    // completion / commit
    input  logic                            done_valid,
    input  logic [IDXW-1:0]                 done_index,
    input  logic                            commit_valid,
    output logic                            commit_error,
    // store queue retirement
    input  logic                            stq_free_valid,
    input  logic [$clog2(STQ_BUF_SIZE)-1:0] stq_free_index,
    // control / status
    input  logic                            flush,
    output logic [IDXW:0]                   count,
    output logic                            empty,
    output logic                            full
);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [IDXW:0]              r_head;
    logic [IDXW:0]              r_tail;
    logic                       r_commit_error;

    // Per-entry state
    logic [LDQ_SIZE-1:0]        r_valid;
    logic [LDQ_SIZE-1:0]        r_addr_valid;
    logic [LDQ_SIZE-1:0]        r_executed;
    logic [LDQ_SIZE-1:0]        r_succeeded;
    logic [XLEN-1:0]            r_addr       [LDQ_SIZE];
    logic [STQ_BUF_SIZE-1:0]    r_store_mask [LDQ_SIZE];
    logic [ROB_TAG_WIDTH-1:0]   r_rob_tag    [LDQ_SIZE];

    logic [IDXW-1:0]            w_head_idx;
    logic [IDXW-1:0]            w_tail_idx;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_alloc_fire;
    logic                       w_commit_ok;
    logic                       w_commit_fire;
    logic                       w_issue_valid;
    logic [IDXW-1:0]            w_issue_idx;
    logic                       w_issue_fire;
    logic [LDQ_SIZE-1:0]        w_candidate;
    logic [STQ_BUF_SIZE-1:0]    w_free_clear;

    assign w_head_idx    = r_head[IDXW-1:0];
    assign w_tail_idx    = r_tail[IDXW-1:0];
    assign w_empty       = (r_head == r_tail);
    assign w_full        = (r_head[IDXW] != r_tail[IDXW]) && (w_head_idx == w_tail_idx);

    // Flush outranks every other request in the same cycle.
    assign w_alloc_fire  = alloc_valid && !w_full && !flush;
    assign w_commit_ok   = commit_valid && r_valid[w_head_idx] && r_succeeded[w_head_idx];
    assign w_commit_fire = w_commit_ok && !flush;
    assign w_issue_fire  = w_issue_valid && issue_ready && !flush;

    assign w_candidate   = r_valid & r_addr_valid & ~r_executed;
    assign w_free_clear  = stq_free_valid ? (STQ_BUF_SIZE'(1) << stq_free_index)
                                          : '0;

    // Oldest-first select: scan youngest to oldest so the last hit is the oldest.
    always_comb begin
        logic [IDXW-1:0] w_scan_idx;
        w_issue_valid = 1'b0;
        w_issue_idx   = '0;
        w_scan_idx    = '0;
        for (int k = LDQ_SIZE - 1; k >= 0; k--) begin
            w_scan_idx = w_head_idx + IDXW'(k);
            if (w_candidate[w_scan_idx]) begin
                w_issue_valid = 1'b1;
                w_issue_idx   = w_scan_idx;
            end
        end
    end

    // Head/tail pointers and the one-cycle commit error pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_commit_error <= 1'b0;
        end else if (flush) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_commit_error <= 1'b0;
        end else begin
            if (w_alloc_fire) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_commit_fire) begin
                r_head <= r_head + 1'b1;
            end
            r_commit_error <= commit_valid && !w_commit_ok;
        end
    end

    // Entry status flags; a fresh allocation starts with all flags clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid      <= '0;
            r_addr_valid <= '0;
            r_executed   <= '0;
            r_succeeded  <= '0;
        end else if (flush) begin
            r_valid      <= '0;
            r_addr_valid <= '0;
            r_executed   <= '0;
            r_succeeded  <= '0;
        end else begin
            for (int i = 0; i < LDQ_SIZE; i++) begin
                if (w_alloc_fire && (w_tail_idx == IDXW'(i))) begin
                    r_valid[i]      <= 1'b1;
                    r_addr_valid[i] <= 1'b0;
                    r_executed[i]   <= 1'b0;
                    r_succeeded[i]  <= 1'b0;
                end else begin
                    if (w_commit_fire && (w_head_idx == IDXW'(i))) begin
                        r_valid[i] <= 1'b0;
                    end
                    if (addr_valid && (addr_index == IDXW'(i)) && r_valid[i]) begin
                        r_addr_valid[i] <= 1'b1;
                    end
                    if (w_issue_fire && (w_issue_idx == IDXW'(i))) begin
                        r_executed[i] <= 1'b1;
                    end
                    if (done_valid && (done_index == IDXW'(i)) && r_valid[i] && r_executed[i]) begin
                        r_succeeded[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Entry payload; only meaningful while the entry is valid, so no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LDQ_SIZE; i++) begin
            if (w_alloc_fire && (w_tail_idx == IDXW'(i))) begin
                r_rob_tag[i]    <= alloc_rob_tag;
                r_store_mask[i] <= alloc_store_mask & ~w_free_clear;
            end else begin
                r_store_mask[i] <= r_store_mask[i] & ~w_free_clear;
            end
            if (!flush && addr_valid && (addr_index == IDXW'(i)) && r_valid[i]) begin
                r_addr[i] <= addr;
            end
        end
    end

    assign alloc_ready      = !w_full;
    assign alloc_index      = w_tail_idx;
    assign issue_valid      = w_issue_valid;
    assign issue_index      = w_issue_idx;
    assign issue_address    = r_addr[w_issue_idx];
    assign issue_store_mask = r_store_mask[w_issue_idx];
    assign issue_rob_tag    = r_rob_tag[w_issue_idx];
    assign commit_error     = r_commit_error;
    assign count            = r_tail - r_head;
    assign empty            = w_empty;
    assign full             = w_full;

endmodule
`default_nettype wire

// File: tb/tb_load_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_queue
// Description : Self-checking bench for load_queue: directed vector table,
//               hand-written corner sequences and randomized traffic against
//               an age-ordered queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_queue;

    localparam int XLEN = 32;
    localparam int LDQ  = 8;
    localparam int SQ   = 8;
    localparam int TW   = 5;
    localparam int IW   = 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            alloc_valid;
    logic [TW-1:0]   alloc_rob_tag;
    logic [SQ-1:0]   alloc_store_mask;
    logic            alloc_ready;
    logic [IW-1:0]   alloc_index;
    logic            addr_valid;
    logic [IW-1:0]   addr_index;
    logic [XLEN-1:0] addr;
    logic            issue_valid;
    logic            issue_ready;
    logic [IW-1:0]   issue_index;
    logic [XLEN-1:0] issue_address;
    logic [SQ-1:0]   issue_store_mask;
    logic [TW-1:0]   issue_rob_tag;
    logic            done_valid;
    logic [IW-1:0]   done_index;
    logic            commit_valid;
    logic            commit_error;
    logic            stq_free_valid;
    logic [2:0]      stq_free_index;
    logic            flush;
    logic [IW:0]     count;
    logic            empty;
    logic            full;

    always #5 clk = ~clk;

    load_queue #(
        .XLEN(XLEN), .LDQ_SIZE(LDQ), .STQ_BUF_SIZE(SQ), .ROB_TAG_WIDTH(TW), .IDXW(IW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .alloc_valid(alloc_valid), .alloc_rob_tag(alloc_rob_tag),
        .alloc_store_mask(alloc_store_mask), .alloc_ready(alloc_ready),
        .alloc_index(alloc_index),
        .addr_valid(addr_valid), .addr_index(addr_index), .addr(addr),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_index(issue_index), .issue_address(issue_address),
        .issue_store_mask(issue_store_mask), .issue_rob_tag(issue_rob_tag),
        .done_valid(done_valid), .done_index(done_index),
        .commit_valid(commit_valid), .commit_error(commit_error),
        .stq_free_valid(stq_free_valid), .stq_free_index(stq_free_index),
        .flush(flush), .count(count), .empty(empty), .full(full)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: program-ordered list of slots -------
    int          m_order[$];
    int          m_head;
    bit          m_addrv [LDQ];
    bit          m_exec  [LDQ];
    bit          m_succ  [LDQ];
    logic [31:0] m_addr  [LDQ];
    logic [7:0]  m_mask  [LDQ];
    logic [4:0]  m_tag   [LDQ];
    bit          m_err;

    function automatic bit in_q(input int s);
        foreach (m_order[k]) if (m_order[k] == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_pick();
        foreach (m_order[k]) if (m_addrv[m_order[k]] && !m_exec[m_order[k]]) return m_order[k];
        return -1;
    endfunction

    task automatic model_reset();
        m_order.delete();
        m_head = 0;
        m_err  = 1'b0;
        for (int s = 0; s < LDQ; s++) begin
            m_addrv[s] = 1'b0; m_exec[s] = 1'b0; m_succ[s] = 1'b0;
        end
    endtask

    task automatic model_update();
        int pick, n, s;
        bit vdone, vaddr, hsucc;
        pick = m_pick();
        n    = m_order.size();
        if (flush) begin
            model_reset();
            return;
        end
        vdone = in_q(int'(done_index)) && m_exec[done_index];
        vaddr = in_q(int'(addr_index));
        hsucc = (n > 0) && m_succ[m_order[0]];
        m_err = commit_valid && !hsucc;
        if (stq_free_valid)
            for (int t = 0; t < LDQ; t++) m_mask[t][stq_free_index] = 1'b0;
        if (done_valid && vdone) m_succ[done_index] = 1'b1;
        if (issue_ready && pick >= 0) m_exec[pick] = 1'b1;
        if (addr_valid && vaddr) begin
            m_addrv[addr_index] = 1'b1;
            m_addr[addr_index]  = addr;
        end
        if (alloc_valid && n < LDQ) begin
            s = (m_head + n) % LDQ;
            m_tag[s]  = alloc_rob_tag;
            m_mask[s] = alloc_store_mask;
            if (stq_free_valid) m_mask[s][stq_free_index] = 1'b0;
            m_addrv[s] = 1'b0; m_exec[s] = 1'b0; m_succ[s] = 1'b0;
            m_order.push_back(s);
        end
        if (commit_valid && hsucc) begin
            void'(m_order.pop_front());
            m_head = (m_head + 1) % LDQ;
        end
    endtask

    task automatic compare_model();
        int n, pick;
        n    = m_order.size();
        pick = m_pick();
        check("count",        count,        n);
        check("empty",        empty,        n == 0);
        check("full",         full,         n == LDQ);
        check("alloc_ready",  alloc_ready,  n != LDQ);
        check("alloc_index",  alloc_index,  (m_head + n) % LDQ);
        check("commit_error", commit_error, m_err);
        check("issue_valid",  issue_valid,  pick >= 0);
        if (pick >= 0 && issue_valid) begin
            check("issue_index",      issue_index,      pick);
            check("issue_address",    issue_address,    m_addr[pick]);
            check("issue_store_mask", issue_store_mask, m_mask[pick]);
            check("issue_rob_tag",    issue_rob_tag,    m_tag[pick]);
        end
    endtask

    task automatic idle();
        alloc_valid = 0; alloc_rob_tag = '0; alloc_store_mask = '0;
        addr_valid = 0; addr_index = '0; addr = '0;
        issue_ready = 0; done_valid = 0; done_index = '0;
        commit_valid = 0; stq_free_valid = 0; stq_free_index = '0; flush = 0;
    endtask

    // One clock: model and DUT see the same inputs at the edge.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_model();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_empty"},        empty,        1);
        check({tag, "_full"},         full,         0);
        check({tag, "_count"},        count,        0);
        check({tag, "_alloc_ready"},  alloc_ready,  1);
        check({tag, "_issue_valid"},  issue_valid,  0);
        check({tag, "_alloc_index"},  alloc_index,  0);
        check({tag, "_commit_error"}, commit_error, 0);
    endtask

    // ---------------- directed vector table --------------------------------
    typedef struct {
        bit av; logic [4:0] tag; logic [7:0] mask;
        bit adv; logic [2:0] adi; logic [31:0] ad;
        bit ir; bit dv; logic [2:0] di; bit cv; bit fv; logic [2:0] fi; bit fl;
        int ecount; bit eiv; logic [2:0] eidx; logic [31:0] eaddr; logic [7:0] emask; bit eerr;
    } vec_t;

    vec_t vt[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           av tag   mask   adv adi ad          ir dv di cv fv fi fl | cnt iv idx addr       mask   err
        vt[0]  = '{1, 5'd0, 8'h00, 0, 3'd0, 32'h0,    0, 0, 3'd0, 0, 0, 3'd0, 0, 1, 0, 3'd0, 32'h0,   8'h00, 0};
        vt[1]  = '{1, 5'd1, 8'h06, 0, 3'd0, 32'h0,    0, 0, 3'd0, 0, 0, 3'd0, 0, 2, 0, 3'd0, 32'h0,   8'h00, 0};
        vt[2]  = '{1, 5'd2, 8'h00, 0, 3'd0, 32'h0,    0, 0, 3'd0, 0, 0, 3'd0, 0, 3, 0, 3'd0, 32'h0,   8'h00, 0};
        vt[3]  = '{0, 5'd0, 8'h00, 1, 3'd2, 32'h100,  0, 0, 3'd0, 0, 0, 3'd0, 0, 3, 1, 3'd2, 32'h100, 8'h00, 0};
        vt[4]  = '{0, 5'd0, 8'h00, 1, 3'd0, 32'h200,  0, 0, 3'd0, 0, 0, 3'd0, 0, 3, 1, 3'd0, 32'h200, 8'h00, 0};
        vt[5]  = '{0, 5'd0, 8'h00, 0, 3'd0, 32'h0,    1, 0, 3'd0, 0, 0, 3'd0, 0, 3, 1, 3'd2, 32'h100, 8'h00, 0};
        vt[6]  = '{0, 5'd0, 8'h00, 0, 3'd0, 32'h0,    0, 1, 3'd0, 0, 0, 3'd0, 0, 3, 1, 3'd2, 32'h100, 8'h00, 0};
        vt[7]  = '{0, 5'd0, 8'h00, 0, 3'd0, 32'h0,    0, 0, 3'd0, 1, 0, 3'd0, 0, 2, 1, 3'd2, 32'h100, 8'h00, 0};
        vt[8]  = '{0, 5'd0, 8'h00, 0, 3'd0, 32'h0,    0, 0, 3'd0, 1, 0, 3'd0, 0, 2, 1, 3'd2, 32'h100, 8'h00, 1};
        vt[9]  = '{0, 5'd0, 8'h00, 0, 3'd0, 32'h0,    0, 0, 3'd0, 0, 0, 3'd0, 0, 2, 1, 3'd2, 32'h100, 8'h00, 0};
        vt[10] = '{0, 5'd0, 8'h00, 1, 3'd1, 32'h300,  0, 0, 3'd0, 0, 1, 3'd1, 0, 2, 1, 3'd1, 32'h300, 8'h04, 0};
        vt[11] = '{1, 5'd9, 8'h00, 0, 3'd0, 32'h0,    0, 0, 3'd0, 1, 0, 3'd0, 1, 0, 0, 3'd0, 32'h0,   8'h00, 0};

        idle();
        model_reset();
        reset_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        check_reset_state("reset");

        // Directed table
        for (int i = 0; i < 12; i++) begin
            idle();
            alloc_valid = vt[i].av; alloc_rob_tag = vt[i].tag; alloc_store_mask = vt[i].mask;
            addr_valid = vt[i].adv; addr_index = vt[i].adi; addr = vt[i].ad;
            issue_ready = vt[i].ir; done_valid = vt[i].dv; done_index = vt[i].di;
            commit_valid = vt[i].cv; stq_free_valid = vt[i].fv; stq_free_index = vt[i].fi;
            flush = vt[i].fl;
            step();
            check($sformatf("vec%0d_count", i),        count,        vt[i].ecount);
            check($sformatf("vec%0d_issue_valid", i),  issue_valid,  vt[i].eiv);
            check($sformatf("vec%0d_commit_error", i), commit_error, vt[i].eerr);
            if (vt[i].eiv) begin
                check($sformatf("vec%0d_issue_index", i),   issue_index,      vt[i].eidx);
                check($sformatf("vec%0d_issue_address", i), issue_address,    vt[i].eaddr);
                check($sformatf("vec%0d_issue_mask", i),    issue_store_mask, vt[i].emask);
            end
        end
        idle();
        step();
        check("post_flush_alloc_index", alloc_index, 0);

        // Fill to capacity, then an ignored 9th allocation
        for (int t = 0; t < LDQ; t++) begin
            idle(); alloc_valid = 1; alloc_rob_tag = 5'(t);
            step();
        end
        check("fill_full",        full,        1);
        check("fill_alloc_ready", alloc_ready, 0);
        check("fill_count",       count,       8);
        idle(); alloc_valid = 1; alloc_rob_tag = 5'd31;
        step();
        check("overfill_count",       count,       8);
        check("overfill_alloc_index", alloc_index, 0);
        idle(); flush = 1;
        step();

        // 13 allocate/execute/commit rounds so indices wrap 7 -> 0
        for (int it = 0; it < 13; it++) begin
            idle();
            check($sformatf("wrap%0d_alloc_index", it), alloc_index, it % LDQ);
            alloc_valid = 1; alloc_rob_tag = 5'(it);
            step();
            idle(); addr_valid = 1; addr_index = 3'(it % LDQ); addr = $urandom;
            step();
            idle(); issue_ready = 1;
            step();
            idle(); done_valid = 1; done_index = 3'(it % LDQ);
            step();
            idle(); commit_valid = 1;
            step();
            check($sformatf("wrap%0d_empty", it), empty, 1);
        end

        // Flush with 5 entries while alloc and commit are also requested
        for (int t = 0; t < 5; t++) begin
            idle(); alloc_valid = 1; alloc_rob_tag = 5'(t);
            step();
        end
        check("pre_flush_count", count, 5);
        idle(); flush = 1; alloc_valid = 1; commit_valid = 1;
        step();
        check("flush_empty",       empty,       1);
        check("flush_count",       count,       0);
        check("flush_issue_valid", issue_valid, 0);
        check("flush_alloc_index", alloc_index, 0);

        // Reset asserted mid-operation takes effect immediately
        for (int t = 0; t < 3; t++) begin
            idle(); alloc_valid = 1; addr_valid = (t > 0); addr_index = 3'(t - 1); addr = 32'h40 * t;
            step();
        end
        idle();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_state("midop_reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            idle();
            alloc_valid      = ($urandom_range(0, 99) < 45);
            alloc_rob_tag    = 5'($urandom);
            alloc_store_mask = 8'($urandom);
            addr_valid       = $urandom_range(0, 1);
            addr_index       = 3'($urandom);
            addr             = $urandom;
            issue_ready      = $urandom_range(0, 1);
            done_valid       = $urandom_range(0, 1);
            done_index       = 3'($urandom);
            foreach (m_order[k])
                if (m_exec[m_order[k]] && !m_succ[m_order[k]] && $urandom_range(0, 1))
                    done_index = 3'(m_order[k]);
            commit_valid     = ($urandom_range(0, 99) < 10) ||
                               (m_order.size() > 0 && m_succ[m_order[0]] && $urandom_range(0, 1));
            stq_free_valid   = ($urandom_range(0, 3) == 0);
            stq_free_index   = 3'($urandom);
            flush            = ($urandom_range(0, 99) == 0);
            step();
        end

        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
